// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and backing-memory-side signals of mem_port_arbiter.
// slave = arbiter view; master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) ();
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          imemError;

  logic          MEM_memRead;
  logic          MEM_memWrite;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dmemError;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_ack;
  logic [DW-1:0] ext_rdata;

  modport slave (
    input  if_req, if_addr, MEM_memRead, MEM_memWrite, dm_addr, dm_wdata,
           ext_ack, ext_rdata,
    output if_rdata, imemError, dm_rdata, dmemError,
           ext_req, ext_we, ext_addr, ext_wdata
  );

  modport master (
    output if_req, if_addr, MEM_memRead, MEM_memWrite, dm_addr, dm_wdata,
           ext_ack, ext_rdata,
    input  if_rdata, imemError, dm_rdata, dmemError,
           ext_req, ext_we, ext_addr, ext_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM stage accesses onto one variable-latency memory port,
// with per-requester read buffers and a write-complete record. Optional MEMARB_RR_EN.
module mem_port_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SERV_I = 2'd1;
  localparam logic [1:0] SERV_D = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          ext_req_q, ext_req_d;
  logic          ext_we_q, ext_we_d;
  logic [AW-1:0] ext_addr_q, ext_addr_d;
  logic [DW-1:0] ext_wdata_q, ext_wdata_d;

  logic          ibuf_valid_q, ibuf_valid_d;
  logic [AW-1:0] ibuf_addr_q, ibuf_addr_d;
  logic [DW-1:0] ibuf_data_q, ibuf_data_d;
  logic          dbuf_valid_q, dbuf_valid_d;
  logic [AW-1:0] dbuf_addr_q, dbuf_addr_d;
  logic [DW-1:0] dbuf_data_q, dbuf_data_d;
  logic          wrec_valid_q, wrec_valid_d;
  logic [AW-1:0] wrec_addr_q, wrec_addr_d;
  logic [DW-1:0] wrec_data_q, wrec_data_d;

  logic ihit, dhit, whit;
  logic i_pend, d_pend;
  logic pick_i, pick_d;

`ifdef MEMARB_RR_EN
  localparam logic RR_I = 1'b0;
  localparam logic RR_D = 1'b1;
  logic rr_ptr_q, rr_ptr_d;
`endif

  assign ihit = ibuf_valid_q & (ibuf_addr_q == bus.if_addr);
  assign dhit = dbuf_valid_q & (dbuf_addr_q == bus.dm_addr);
  assign whit = wrec_valid_q & (wrec_addr_q == bus.dm_addr) & (wrec_data_q == bus.dm_wdata);

  // A store takes precedence over a load presented in the same cycle.
  assign i_pend = bus.if_req & ~ihit;
  assign d_pend = bus.MEM_memWrite ? ~whit : (bus.MEM_memRead & ~dhit);

  assign bus.imemError = i_pend;
  assign bus.dmemError = d_pend;
  assign bus.if_rdata  = ibuf_data_q;
  assign bus.dm_rdata  = dbuf_data_q;
  assign bus.ext_req   = ext_req_q;
  assign bus.ext_we    = ext_we_q;
  assign bus.ext_addr  = ext_addr_q;
  assign bus.ext_wdata = ext_wdata_q;

  // Grant selection when idle.
  always_comb begin
    pick_i = 1'b0;
    pick_d = 1'b0;
`ifdef MEMARB_RR_EN
    if (d_pend && i_pend) begin
      pick_d = (rr_ptr_q == RR_D);
      pick_i = (rr_ptr_q == RR_I);
    end else begin
      pick_d = d_pend;
      pick_i = i_pend;
    end
`else
    pick_d = d_pend;
    pick_i = i_pend & ~d_pend;
`endif
  end

  always_comb begin
    state_d      = state_q;
    ext_req_d    = ext_req_q;
    ext_we_d     = ext_we_q;
    ext_addr_d   = ext_addr_q;
    ext_wdata_d  = ext_wdata_q;
    ibuf_valid_d = ibuf_valid_q;
    ibuf_addr_d  = ibuf_addr_q;
    ibuf_data_d  = ibuf_data_q;
    dbuf_valid_d = dbuf_valid_q;
    dbuf_addr_d  = dbuf_addr_q;
    dbuf_data_d  = dbuf_data_q;
    wrec_valid_d = wrec_valid_q;
    wrec_addr_d  = wrec_addr_q;
    wrec_data_d  = wrec_data_q;
`ifdef MEMARB_RR_EN
    rr_ptr_d     = rr_ptr_q;
`endif

    // The write record only suppresses re-issue of a continuously held store.
    if (!bus.MEM_memWrite) wrec_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          state_d     = SERV_D;
          ext_req_d   = 1'b1;
          ext_we_d    = bus.MEM_memWrite;
          ext_addr_d  = bus.dm_addr;
          ext_wdata_d = bus.dm_wdata;
        end else if (pick_i) begin
          state_d     = SERV_I;
          ext_req_d   = 1'b1;
          ext_we_d    = 1'b0;
          ext_addr_d  = bus.if_addr;
          ext_wdata_d = '0;
        end
`ifdef MEMARB_RR_EN
        if (d_pend && i_pend) rr_ptr_d = pick_d ? RR_I : RR_D;
`endif
      end
      SERV_I: begin
        if (bus.ext_ack) begin
          state_d      = IDLE;
          ext_req_d    = 1'b0;
          ibuf_valid_d = 1'b1;
          ibuf_addr_d  = ext_addr_q;
          ibuf_data_d  = bus.ext_rdata;
        end
      end
      SERV_D: begin
        if (bus.ext_ack) begin
          state_d   = IDLE;
          ext_req_d = 1'b0;
          if (ext_we_q) begin
            wrec_valid_d = 1'b1;
            wrec_addr_d  = ext_addr_q;
            wrec_data_d  = ext_wdata_q;
            // Shared address space: a store makes stale copies in either buffer invalid.
            if (ibuf_addr_q == ext_addr_q) ibuf_valid_d = 1'b0;
            if (dbuf_addr_q == ext_addr_q) dbuf_valid_d = 1'b0;
          end else begin
            dbuf_valid_d = 1'b1;
            dbuf_addr_d  = ext_addr_q;
            dbuf_data_d  = bus.ext_rdata;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        ext_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      ext_req_q    <= 1'b0;
      ext_we_q     <= 1'b0;
      ext_addr_q   <= '0;
      ext_wdata_q  <= '0;
      ibuf_valid_q <= 1'b0;
      ibuf_addr_q  <= '0;
      ibuf_data_q  <= '0;
      dbuf_valid_q <= 1'b0;
      dbuf_addr_q  <= '0;
      dbuf_data_q  <= '0;
      wrec_valid_q <= 1'b0;
      wrec_addr_q  <= '0;
      wrec_data_q  <= '0;
`ifdef MEMARB_RR_EN
      rr_ptr_q     <= RR_D;
`endif
    end else begin
      state_q      <= state_d;
      ext_req_q    <= ext_req_d;
      ext_we_q     <= ext_we_d;
      ext_addr_q   <= ext_addr_d;
      ext_wdata_q  <= ext_wdata_d;
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_addr_q  <= ibuf_addr_d;
      ibuf_data_q  <= ibuf_data_d;
      dbuf_valid_q <= dbuf_valid_d;
      dbuf_addr_q  <= dbuf_addr_d;
      dbuf_data_q  <= dbuf_data_d;
      wrec_valid_q <= wrec_valid_d;
      wrec_addr_q  <= wrec_addr_d;
      wrec_data_q  <= wrec_data_d;
`ifdef MEMARB_RR_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a latency-programmable
// backing-memory responder.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic Clk;
  logic Rst;
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  int lat = 0;
  bit ack_en = 1'b1;
  int stray_req = 0;
  int txn_cnt;
  logic [DW-1:0] mem_model [0:1023];
  logic [AW-1:0] log_addr  [0:63];
  logic          log_we    [0:63];
  logic [DW-1:0] log_wdata [0:63];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Backing memory: acks after 'lat' cycles of ext_req, or a stray ack on request.
  initial begin
    int wcnt;
    int stray_done;
    logic [9:0] idx;
    for (int i = 0; i < 1024; i++) mem_model[i] = '0;
    mem_model[10'h040] = 32'h8C010004;
    mem_model[10'h041] = 32'h55556666;
    mem_model[10'h080] = 32'h33334444;
    mem_model[10'h010] = 32'h11112222;
    mem_model[10'h0C0] = 32'h77778888;
    mem_model[10'h020] = 32'h9999AAAA;
    mem_model[10'h140] = 32'h0BADF00D;
    mem_model[10'h030] = 32'hCAFEF00D;
    mem_model[10'h050] = 32'h14014014;
    bus.ext_ack   = 1'b0;
    bus.ext_rdata = '0;
    wcnt = 0;
    stray_done = 0;
    txn_cnt = 0;
    forever begin
      @(posedge Clk);
      #2;
      idx = bus.ext_addr[11:2];
      if (stray_req != stray_done) begin
        stray_done    = stray_req;
        bus.ext_ack   = 1'b1;
        bus.ext_rdata = 32'hBAD0BAD0;
      end else if (ack_en && bus.ext_req) begin
        if (wcnt >= lat) begin
          bus.ext_ack   = 1'b1;
          bus.ext_rdata = mem_model[idx];
          if (bus.ext_we) mem_model[idx] = bus.ext_wdata;
          if (txn_cnt < 64) begin
            log_addr[6'(txn_cnt)]  = bus.ext_addr;
            log_we[6'(txn_cnt)]    = bus.ext_we;
            log_wdata[6'(txn_cnt)] = bus.ext_wdata;
          end
          txn_cnt = txn_cnt + 1;
          wcnt = 0;
        end else begin
          bus.ext_ack = 1'b0;
          wcnt = wcnt + 1;
        end
      end else begin
        bus.ext_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  task automatic next_cycle;
    @(posedge Clk);
    #1;
  endtask

  // Cycles (from now) until each stall output is first seen low; -1 if never.
  task automatic measure_clear(output int d_clr, output int i_clr);
    d_clr = -1;
    i_clr = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (d_clr < 0 && !bus.dmemError) d_clr = k;
      if (i_clr < 0 && !bus.imemError) i_clr = k;
      if (d_clr >= 0 && i_clr >= 0) break;
      @(posedge Clk);
      #1;
    end
    next_cycle();
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.MEM_memRead = 1'b0;
    bus.MEM_memWrite = 1'b0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    @(negedge Clk);
    checks++; if ({bus.ext_req, bus.ext_we, bus.imemError, bus.dmemError} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl: req/we/istall/dstall=%b expected 0000",
        {bus.ext_req, bus.ext_we, bus.imemError, bus.dmemError}); end
    checks++; if ({bus.ext_addr, bus.ext_wdata, bus.if_rdata, bus.dm_rdata} !== 128'h0) begin
      failures++; $display("FAIL reset_data: addr=%h wdata=%h irdata=%h drdata=%h expected 0",
        bus.ext_addr, bus.ext_wdata, bus.if_rdata, bus.dm_rdata); end
    next_cycle();
  endtask

  task automatic test_ifetch_miss;
    int t0;
    lat = 0;
    t0 = txn_cnt;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    @(negedge Clk);
    checks++; if ({bus.imemError, bus.ext_req} !== 2'b10) begin
      failures++; $display("FAIL if_c0: istall/req=%b expected 10", {bus.imemError, bus.ext_req}); end
    next_cycle();
    @(negedge Clk);
    checks++; if ({bus.imemError, bus.ext_req, bus.ext_we} !== 3'b110 || bus.ext_addr !== 32'h100) begin
      failures++; $display("FAIL if_c1: istall/req/we=%b addr=%h expected 110 addr 100",
        {bus.imemError, bus.ext_req, bus.ext_we}, bus.ext_addr); end
    next_cycle();
    @(negedge Clk);
    checks++; if (bus.imemError !== 1'b0 || bus.if_rdata !== 32'h8C010004) begin
      failures++; $display("FAIL if_c2: istall=%b rdata=%h expected 0 8c010004", bus.imemError, bus.if_rdata); end
    next_cycle();
    @(negedge Clk);
    checks++; if (bus.ext_req !== 1'b0 || bus.imemError !== 1'b0 || (txn_cnt - t0) != 1) begin
      failures++; $display("FAIL if_rehit: req=%b istall=%b txns=%0d expected 0 0 1",
        bus.ext_req, bus.imemError, txn_cnt - t0); end
    next_cycle();
  endtask

  task automatic test_priority;
    int t0, d_clr, i_clr;
    lat = 1;
    t0 = txn_cnt;
    bus.if_addr = 32'h200;
    bus.MEM_memRead = 1'b1;
    bus.dm_addr = 32'h40;
    measure_clear(d_clr, i_clr);
    checks++; if (d_clr != 3 || i_clr != 6) begin
      failures++; $display("FAIL prio_fixed_clear: d_clr=%0d i_clr=%0d expected 3 6", d_clr, i_clr); end
    checks++; if (log_addr[6'(t0)] !== 32'h40 || log_addr[6'(t0 + 1)] !== 32'h200) begin
      failures++; $display("FAIL prio_fixed_order: first=%h second=%h expected 40 200",
        log_addr[6'(t0)], log_addr[6'(t0 + 1)]); end
    checks++; if (bus.dm_rdata !== 32'h11112222 || bus.if_rdata !== 32'h33334444) begin
      failures++; $display("FAIL prio_data: d=%h i=%h expected 11112222 33334444", bus.dm_rdata, bus.if_rdata); end
    t0 = txn_cnt;
    bus.if_addr = 32'h300;
    bus.dm_addr = 32'h80;
    measure_clear(d_clr, i_clr);
`ifdef MEMARB_RR_EN
    checks++; if (d_clr != 6 || i_clr != 3 || log_addr[6'(t0)] !== 32'h300) begin
      failures++; $display("FAIL prio_rr_second: d_clr=%0d i_clr=%0d first=%h expected 6 3 300",
        d_clr, i_clr, log_addr[6'(t0)]); end
`else
    checks++; if (d_clr != 3 || i_clr != 6 || log_addr[6'(t0)] !== 32'h80) begin
      failures++; $display("FAIL prio_fixed_second: d_clr=%0d i_clr=%0d first=%h expected 3 6 80",
        d_clr, i_clr, log_addr[6'(t0)]); end
`endif
    checks++; if (bus.dm_rdata !== 32'h9999AAAA || bus.if_rdata !== 32'h77778888) begin
      failures++; $display("FAIL prio_data2: d=%h i=%h expected 9999aaaa 77778888", bus.dm_rdata, bus.if_rdata); end
  endtask

  task automatic test_store;
    int t0, d_clr, i_clr, writes;
    lat = 0;
    bus.if_addr = 32'h40;
    bus.dm_addr = 32'h40;
    measure_clear(d_clr, i_clr);
    t0 = txn_cnt;
    bus.if_addr = 32'h500;
    bus.MEM_memRead = 1'b0;
    bus.MEM_memWrite = 1'b1;
    bus.dm_wdata = 32'h0000DEAD;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (k == 5) begin
        checks++; if (bus.dmemError !== 1'b0 || bus.imemError !== 1'b0 || bus.if_rdata !== 32'h0BADF00D) begin
          failures++; $display("FAIL store_held: dstall=%b istall=%b irdata=%h expected 0 0 0badf00d",
            bus.dmemError, bus.imemError, bus.if_rdata); end
      end
      next_cycle();
    end
    writes = 0;
    for (int j = t0; j < txn_cnt; j++) if (log_we[6'(j)]) writes++;
    checks++; if (writes != 1 || (txn_cnt - t0) != 2) begin
      failures++; $display("FAIL store_once: writes=%0d txns=%0d expected 1 2", writes, txn_cnt - t0); end
    checks++; if (log_addr[6'(t0)] !== 32'h40 || log_wdata[6'(t0)] !== 32'h0000DEAD || log_we[6'(t0)] !== 1'b1) begin
      failures++; $display("FAIL store_txn: addr=%h wdata=%h we=%b expected 40 dead 1",
        log_addr[6'(t0)], log_wdata[6'(t0)], log_we[6'(t0)]); end
    bus.MEM_memWrite = 1'b0;
    bus.MEM_memRead = 1'b1;
    @(negedge Clk);
    checks++; if (bus.dmemError !== 1'b1) begin
      failures++; $display("FAIL store_dbuf_inval: dstall=%b expected 1", bus.dmemError); end
    next_cycle();
    measure_clear(d_clr, i_clr);
    checks++; if (bus.dm_rdata !== 32'h0000DEAD) begin
      failures++; $display("FAIL store_reload: drdata=%h expected 0000dead", bus.dm_rdata); end
    bus.MEM_memRead = 1'b0;
    bus.if_addr = 32'h40;
    measure_clear(d_clr, i_clr);
    bus.if_req = 1'b0;
    bus.MEM_memWrite = 1'b1;
    bus.dm_wdata = 32'h0000BEEF;
    measure_clear(d_clr, i_clr);
    bus.dm_wdata = 32'h0000BEF0;
    @(negedge Clk);
    checks++; if (bus.dmemError !== 1'b1) begin
      failures++; $display("FAIL wrec_newdata: dstall=%b expected 1", bus.dmemError); end
    next_cycle();
    measure_clear(d_clr, i_clr);
    bus.MEM_memWrite = 1'b0;
    next_cycle();
    bus.MEM_memWrite = 1'b1;
    @(negedge Clk);
    checks++; if (bus.dmemError !== 1'b1) begin
      failures++; $display("FAIL wrec_cleared: dstall=%b expected 1", bus.dmemError); end
    next_cycle();
    measure_clear(d_clr, i_clr);
    bus.MEM_memWrite = 1'b0;
    bus.if_req = 1'b1;
    @(negedge Clk);
    checks++; if (bus.imemError !== 1'b1) begin
      failures++; $display("FAIL store_ibuf_inval: istall=%b expected 1", bus.imemError); end
    next_cycle();
    measure_clear(d_clr, i_clr);
    checks++; if (bus.if_rdata !== 32'h0000BEF0) begin
      failures++; $display("FAIL store_refetch: irdata=%h expected 0000bef0", bus.if_rdata); end
  endtask

  task automatic test_long_latency;
    lat = 10;
    bus.MEM_memRead = 1'b1;
    bus.dm_addr = 32'hC0;
    bus.dm_wdata = 32'h12345678;
    @(negedge Clk);
    checks++; if (bus.dmemError !== 1'b1) begin
      failures++; $display("FAIL lat_c0: dstall=%b expected 1", bus.dmemError); end
    next_cycle();
    for (int k = 1; k <= 11; k++) begin
      @(negedge Clk);
      checks++; if ({bus.ext_req, bus.dmemError} !== 2'b11 || bus.ext_addr !== 32'hC0 ||
                    bus.ext_wdata !== 32'h12345678) begin
        failures++; $display("FAIL lat_hold_c%0d: req/dstall=%b addr=%h wdata=%h expected 11 c0 12345678",
          k, {bus.ext_req, bus.dmemError}, bus.ext_addr, bus.ext_wdata); end
      next_cycle();
      if (k == 4) bus.dm_wdata = 32'hFFFF0000;
    end
    @(negedge Clk);
    checks++; if (bus.dmemError !== 1'b0 || bus.dm_rdata !== 32'hCAFEF00D || bus.ext_req !== 1'b0) begin
      failures++; $display("FAIL lat_release: dstall=%b drdata=%h req=%b expected 0 cafef00d 0",
        bus.dmemError, bus.dm_rdata, bus.ext_req); end
    next_cycle();
  endtask

  task automatic test_reset_mid;
    int d_clr, i_clr;
    lat = 0;
    ack_en = 1'b0;
    bus.dm_addr = 32'h140;
    next_cycle();
    @(negedge Clk);
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h140) begin
      failures++; $display("FAIL rst_pre: req=%b addr=%h expected 1 140", bus.ext_req, bus.ext_addr); end
    Rst = 1'b1;
    #1;
    checks++; if (bus.ext_req !== 1'b0 || bus.imemError !== 1'b1 || bus.dm_rdata !== 32'h0 || bus.if_rdata !== 32'h0) begin
      failures++; $display("FAIL rst_async: req=%b istall=%b drdata=%h irdata=%h expected 0 1 0 0",
        bus.ext_req, bus.imemError, bus.dm_rdata, bus.if_rdata); end
    bus.if_req = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    stray_req = stray_req + 1;
    @(negedge Clk);
    checks++; if (bus.ext_req !== 1'b0 || bus.dmemError !== 1'b1) begin
      failures++; $display("FAIL rst_idle: req=%b dstall=%b expected 0 1", bus.ext_req, bus.dmemError); end
    next_cycle();
    @(negedge Clk);
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h140 || bus.dmemError !== 1'b1) begin
      failures++; $display("FAIL rst_reissue: req=%b addr=%h dstall=%b expected 1 140 1",
        bus.ext_req, bus.ext_addr, bus.dmemError); end
    ack_en = 1'b1;
    next_cycle();
    measure_clear(d_clr, i_clr);
    checks++; if (d_clr != 1 || bus.dm_rdata !== 32'h14014014) begin
      failures++; $display("FAIL rst_fill: d_clr=%0d drdata=%h expected 1 14014014", d_clr, bus.dm_rdata); end
  endtask

  task automatic test_addr_change;
    int t0, d_clr, i_clr;
    lat = 3;
    bus.MEM_memRead = 1'b0;
    t0 = txn_cnt;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h100;
    @(negedge Clk);
    checks++; if (bus.imemError !== 1'b1) begin
      failures++; $display("FAIL chg_c0: istall=%b expected 1", bus.imemError); end
    next_cycle();
    next_cycle();
    bus.if_addr = 32'h104;
    @(negedge Clk);
    checks++; if (bus.imemError !== 1'b1 || bus.ext_addr !== 32'h100 || bus.ext_req !== 1'b1) begin
      failures++; $display("FAIL chg_c2: istall=%b addr=%h req=%b expected 1 100 1",
        bus.imemError, bus.ext_addr, bus.ext_req); end
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge Clk);
    checks++; if (bus.imemError !== 1'b1 || bus.if_rdata !== 32'h8C010004 || bus.ext_req !== 1'b0) begin
      failures++; $display("FAIL chg_c5: istall=%b irdata=%h req=%b expected 1 8c010004 0",
        bus.imemError, bus.if_rdata, bus.ext_req); end
    next_cycle();
    @(negedge Clk);
    checks++; if (bus.ext_req !== 1'b1 || bus.ext_addr !== 32'h104) begin
      failures++; $display("FAIL chg_c6: req=%b addr=%h expected 1 104", bus.ext_req, bus.ext_addr); end
    next_cycle();
    measure_clear(d_clr, i_clr);
    checks++; if (bus.if_rdata !== 32'h55556666 || (txn_cnt - t0) != 2 || log_addr[6'(t0 + 1)] !== 32'h104) begin
      failures++; $display("FAIL chg_done: irdata=%h txns=%0d second=%h expected 55556666 2 104",
        bus.if_rdata, txn_cnt - t0, log_addr[6'(t0 + 1)]); end
  endtask

  initial begin
    test_reset();
    test_ifetch_miss();
    test_priority();
    test_store();
    test_long_latency();
    test_reset_mid();
    test_addr_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency backing memory between the IF stage (instruction fetch) and the MEM stage (load/store).
- Generates the imemError and dmemError stall requests that the pipeline register controller consumes.
- Holds a one-entry read buffer per requester, so a stalled stage re-presenting the same access completes without a second memory transaction.
- Holds a one-entry write-complete record so a stalled store is not re-issued.

Parameters:
AW, 32, address width (bits)
DW, 32, data width (bits)

Ports:
Clk  input  1  clock, all state updates on posedge
Rst  input  1  asynchronous, active-high reset
if_req  input  1  IF stage requests instruction read
if_addr  input  AW  instruction address
if_rdata  output  DW  instruction data (ibuf_data)
imemError  output  1  IF access not complete, stall
MEM_memRead  input  1  MEM stage load
MEM_memWrite  input  1  MEM stage store
dm_addr  input  AW  data address
dm_wdata  input  DW  store data
dm_rdata  output  DW  load data (dbuf_data)
dmemError  output  1  MEM access not complete, stall
ext_req  output  1  backing memory request, held until ext_ack
ext_we  output  1  1 = write transaction
ext_addr  output  AW  transaction address, stable while ext_req
ext_wdata  output  DW  transaction write data, stable while ext_req
ext_ack  input  1  transaction complete; ext_rdata valid this cycle
ext_rdata  input  DW  read data

Behaviour:
- Reset values (async, immediate):
  - state=IDLE; ext_req, ext_we, ext_addr, ext_wdata = 0.
  - ibuf and dbuf valid=0, addr and data=0; wrec valid=0; rr_ptr=D.
- Hit terms:
  - ihit = ibuf_valid & ibuf_addr==if_addr.
  - dhit = dbuf_valid & dbuf_addr==dm_addr.
  - whit = wrec_valid & wrec_addr==dm_addr & wrec_data==dm_wdata.
- Pending terms:
  - i_pend = if_req & ~ihit.
  - d_pend = (MEM_memRead & ~dhit) | (MEM_memWrite & ~whit).
  - MEM_memWrite has precedence if both read and write are asserted.
- Stall outputs are combinational: imemError=i_pend, dmemError=d_pend. Both go 0 when the stage's request is deasserted.
- FSM states: IDLE, SERV_I, SERV_D.
  - IDLE: if d_pend, go to SERV_D; else if i_pend, go to SERV_I. D has fixed priority.
  - On a grant, register ext_req=1, ext_we=MEM_memWrite (0 for I), ext_addr, and ext_wdata.
  - SERV_x: hold all ext_* stable until ext_ack.
  - On ext_ack: ext_req=0, next state IDLE.
  - I read ack: ibuf <= {1, ext_addr, ext_rdata}.
  - D read ack: dbuf <= {1, ext_addr, ext_rdata}.
  - D write ack: wrec <= {1, ext_addr, ext_wdata}. Also invalidate ibuf and dbuf if their addr == ext_addr.
- At least one IDLE cycle between transactions.
- Minimum miss penalty: stall in request cycle c0, ext_req rises c1, ack at c1 earliest, hit and stall released at c2.
- wrec is cleared on any cycle with MEM_memWrite=0. A new store to a different addr/data misses.
- Request inputs changing mid-service do not abort the transaction. It completes and fills the buffer. The stage then re-evaluates its hit against the new address.
- ext_ack in IDLE is ignored.
- Rst during SERV drops ext_req at once and invalidates all buffers. A late ack after reset is ignored.
- Buffers never invalidate except on reset or a matching write. Instruction and data share the address space.

Optional Feature:
MEMARB_RR_EN
- Defined: when both i_pend and d_pend are set in IDLE, grant the requester named by rr_ptr. rr_ptr flips to the other requester on each grant made while both are pending.
- Not defined: fixed D-over-I priority, and rr_ptr is absent.

Test Plan:
1. Reset, then if_req=1 with if_addr=0x100, ext_ack one cycle after ext_req with rdata=0x8C010004 -> imemError=1 for 2 cycles, then 0 with if_rdata=0x8C010004. Second request to 0x100 gives no ext_req.
2. if_req to 0x200 and MEM_memRead to 0x40 in the same cycle -> D served first, I second. dmemError clears before imemError. With MEMARB_RR_EN, a second simultaneous miss is served I first.
3. Store 0x40 <= 0xDEAD held for 6 cycles while IF is also missing -> exactly one ext_we=1 transaction. ibuf or dbuf holding 0x40 is invalidated. A following load from 0x40 misses.
4. ext_ack held low 10 cycles -> ext_req, ext_addr and ext_wdata remain stable and the stall remains asserted throughout. Release -> buffer filled, stall drops next cycle.
5. Assert Rst while in SERV_D, then pulse ext_ack after release -> ext_req=0 immediately, all buffers invalid, the stray ack is ignored, and the next load re-issues.
6. if_addr changes 0x100 -> 0x104 during SERV_I -> the 0x100 fetch completes into ibuf, imemError stays 1, and a new transaction for 0x104 follows.
